acl2_spi_responder: RTL

- Synthesizable SPI mode-0 responder that emulates the ADXL362 (PmodACL2) register interface, i.e. the slave end of the accelerometer SPI link our master drives.
- Serves device ID, status and X/Y/Z sample registers from parallel inputs, and accepts register writes (POWER_CTL, FILTER_CTL, soft reset).
- Used for loopback on a second Pmod header and as a synthesizable bench partner for the master.
- Runs entirely in the system clock domain and oversamples the SPI pins.

---
 rtl/acl2_regs_pkg.sv | 86 ++++++++
 rtl/spi_sync_edge.sv | 38 +++
 rtl/acl2_spi_responder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/acl2_regs_pkg.sv
// Register map, opcodes, reset defaults and FSM states shared by the
// ADXL362-style SPI responder.
package acl2_regs_pkg;

  // SPI command opcodes
  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_FIFO  = 8'h0D;

  // Register addresses
  localparam logic [5:0] ADDR_DEVID_AD   = 6'h00;
  localparam logic [5:0] ADDR_DEVID_MST  = 6'h01;
  localparam logic [5:0] ADDR_PARTID     = 6'h02;
  localparam logic [5:0] ADDR_REVID      = 6'h03;
  localparam logic [5:0] ADDR_STATUS     = 6'h0B;
  localparam logic [5:0] ADDR_XDATA_L    = 6'h0E;
  localparam logic [5:0] ADDR_XDATA_H    = 6'h0F;
  localparam logic [5:0] ADDR_YDATA_L    = 6'h10;
  localparam logic [5:0] ADDR_YDATA_H    = 6'h11;
  localparam logic [5:0] ADDR_ZDATA_L    = 6'h12;
  localparam logic [5:0] ADDR_ZDATA_H    = 6'h13;
  localparam logic [5:0] ADDR_SOFT_RESET = 6'h1F;
  localparam logic [5:0] ADDR_FILTER_CTL = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL  = 6'h2D;
  localparam logic [5:0] ADDR_WR_LAST    = 6'h2E;

  // Fixed values and reset defaults
  localparam logic [7:0] DEVID_AD_VAL   = 8'hAD;
  localparam logic [7:0] DEVID_MST_VAL  = 8'h1D;
  localparam logic [7:0] FILTER_CTL_RST = 8'h13;
  localparam logic [7:0] POWER_CTL_RST  = 8'h00;
  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

  // Writable window 0x1F..0x2E is stored as 16 bytes; index = addr - 0x1F
  localparam int NUM_WREGS = 16;
  localparam logic [3:0] FILTER_CTL_IDX = 4'hD;
  localparam logic [3:0] POWER_CTL_IDX  = 4'hE;

  typedef logic [NUM_WREGS-1:0][7:0] wregs_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR_RD = 3'd2,
    ST_DATA_RD = 3'd3,
    ST_ADDR_WR = 3'd4,
    ST_DATA_WR = 3'd5,
    ST_IGNORE  = 3'd6
  } state_t;

  // Address falls inside the writable window
  function automatic logic is_writable(input logic [5:0] a);
    return (a >= ADDR_SOFT_RESET) && (a <= ADDR_WR_LAST);
  endfunction

  // Start address that consumes the sample (clears DATA_READY)
  function automatic logic is_sample_addr(input logic [5:0] a);
    return (a >= ADDR_XDATA_L) && (a <= ADDR_ZDATA_H);
  endfunction

  // Storage index of a writable address; (addr - 0x1F) mod 16 = addr[3:0] + 1
  function automatic logic [3:0] wreg_index(input logic [3:0] lo);
    return lo + 4'd1;
  endfunction

  // Low byte, or sign-extended high byte, of a 12-bit sample
  function automatic logic [7:0] sample_byte(input logic [11:0] s, input logic hi);
    logic [7:0] v;
    if (hi) begin
      v = {{4{s[11]}}, s[11:8]};
    end else begin
      v = s[7:0];
    end
    return v;
  endfunction

  // Reset contents of the writable window
  function automatic wregs_t wregs_default();
    wregs_t w;
    w = '0;
    w[FILTER_CTL_IDX] = FILTER_CTL_RST;
    w[POWER_CTL_IDX]  = POWER_CTL_RST;
    return w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with registered rise/fall pulses; an edge is
// reported one clk after the synchronized level changes.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;
  logic              r_rise;
  logic              r_fall;
  logic              w_sync;

  assign w_sync = r_chain[STAGES-1];
  assign o_rise = r_rise;
  assign o_fall = r_fall;

  // Synchronizer chain and one-cycle edge pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= {STAGES{1'b0}};
      r_prev  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
      r_prev  <= w_sync;
      r_rise  <= w_sync & ~r_prev;
      r_fall  <= ~w_sync & r_prev;
    end
  end

endmodule

// File: rtl/acl2_spi_responder.sv
// SPI mode-0 responder emulating the ADXL362 register interface. All logic
// runs on clk; the SPI pins are oversampled through synchronizers.
module acl2_spi_responder
  import acl2_regs_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] PART_ID     = 8'hF2,
  parameter logic [7:0] REV_ID      = 8'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        chip_select,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [11:0] x_in,
  input  logic [11:0] y_in,
  input  logic [11:0] z_in,
  input  logic        sample_valid,
  output logic [7:0]  power_ctl,
  output logic        measure_on,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data
);

  logic                   w_sclk_rise, w_sclk_fall;
  logic [SYNC_STAGES-1:0] r_cs_sync, r_mosi_sync;
  logic                   w_cs_sync, w_mosi_sync;

  state_t      r_state, w_state_nx;
  logic [2:0]  r_bit_cnt, w_bit_cnt_nx;
  logic [7:0]  r_rx, w_rx_nx, w_rx_byte;
  logic [7:0]  r_tx, w_tx_nx;
  logic [5:0]  r_addr, w_addr_nx;
  logic        r_miso, w_miso_nx, r_miso_oe;
  logic        r_wr_strobe, w_wr_strobe_nx;
  logic [5:0]  r_wr_addr, w_wr_addr_nx;
  logic [7:0]  r_wr_data, w_wr_data_nx;
  wregs_t      r_wregs, w_wregs_nx;
  logic [11:0] r_snap_x, r_snap_y, r_snap_z;
  logic [11:0] w_snap_x_nx, w_snap_y_nx, w_snap_z_nx;
  logic        r_dready, w_dready_nx, w_dready_clr;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    (sclk),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  assign w_cs_sync   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_sync = r_mosi_sync[SYNC_STAGES-1];
  assign w_rx_byte   = {r_rx[6:0], w_mosi_sync};

  assign miso       = r_miso;
  assign miso_oe    = r_miso_oe;
  assign wr_strobe  = r_wr_strobe;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign power_ctl  = r_wregs[POWER_CTL_IDX];
  assign measure_on = (r_wregs[POWER_CTL_IDX][1:0] == 2'b10);

  // Register read mux; x/y/z come from whichever sample source the caller picks
  function automatic logic [7:0] read_reg(input logic [5:0] a, input logic [11:0] x,
                                          input logic [11:0] y, input logic [11:0] z,
                                          input logic dr, input wregs_t wr);
    logic [7:0] v;
    v = 8'h00;
    if (is_writable(a)) begin
      v = wr[wreg_index(a[3:0])];
    end else begin
      case (a)
        ADDR_DEVID_AD:  v = DEVID_AD_VAL;
        ADDR_DEVID_MST: v = DEVID_MST_VAL;
        ADDR_PARTID:    v = PART_ID;
        ADDR_REVID:     v = REV_ID;
        ADDR_STATUS:    v = {7'b0000000, dr};
        ADDR_XDATA_L:   v = sample_byte(x, 1'b0);
        ADDR_XDATA_H:   v = sample_byte(x, 1'b1);
        ADDR_YDATA_L:   v = sample_byte(y, 1'b0);
        ADDR_YDATA_H:   v = sample_byte(y, 1'b1);
        ADDR_ZDATA_L:   v = sample_byte(z, 1'b0);
        ADDR_ZDATA_H:   v = sample_byte(z, 1'b1);
        default:        v = 8'h00;
      endcase
    end
    return v;
  endfunction

  // Plain synchronizers for chip_select (idles high) and mosi
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs_sync   <= {SYNC_STAGES{1'b1}};
      r_mosi_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], chip_select};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next state, shift registers, register file and sample bookkeeping
  always_comb begin
    w_state_nx     = r_state;
    w_bit_cnt_nx   = r_bit_cnt;
    w_rx_nx        = r_rx;
    w_tx_nx        = r_tx;
    w_addr_nx      = r_addr;
    w_miso_nx      = r_miso;
    w_wr_strobe_nx = 1'b0;
    w_wr_addr_nx   = r_wr_addr;
    w_wr_data_nx   = r_wr_data;
    w_wregs_nx     = r_wregs;
    w_snap_x_nx    = r_snap_x;
    w_snap_y_nx    = r_snap_y;
    w_snap_z_nx    = r_snap_z;
    w_dready_clr   = 1'b0;

    if (w_cs_sync) begin
      // Frame over (or never started): drop any partial byte
      w_state_nx   = ST_IDLE;
      w_bit_cnt_nx = 3'd0;
      w_rx_nx      = 8'h00;
      w_tx_nx      = 8'h00;
      w_miso_nx    = 1'b0;
    end else if (r_state == ST_IDLE) begin
      w_state_nx   = ST_CMD;
      w_bit_cnt_nx = 3'd0;
      w_rx_nx      = 8'h00;
      w_tx_nx      = 8'h00;
      w_miso_nx    = 1'b0;
    end else begin
      if (w_sclk_rise) begin
        w_rx_nx      = w_rx_byte;
        w_bit_cnt_nx = r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          case (r_state)
            ST_CMD: begin
              case (w_rx_byte)
                CMD_READ:  w_state_nx = ST_ADDR_RD;
                CMD_WRITE: w_state_nx = ST_ADDR_WR;
                CMD_FIFO:  w_state_nx = ST_IGNORE;
                default:   w_state_nx = ST_IGNORE;
              endcase
            end
            ST_ADDR_RD: begin
              // First byte reads the live inputs, which are also what gets latched
              w_snap_x_nx  = x_in;
              w_snap_y_nx  = y_in;
              w_snap_z_nx  = z_in;
              w_tx_nx      = read_reg(w_rx_byte[5:0], x_in, y_in, z_in, r_dready, r_wregs);
              w_addr_nx    = w_rx_byte[5:0] + 6'd1;
              w_dready_clr = is_sample_addr(w_rx_byte[5:0]);
              w_state_nx   = ST_DATA_RD;
            end
            ST_DATA_RD: begin
              w_tx_nx   = read_reg(r_addr, r_snap_x, r_snap_y, r_snap_z, r_dready, r_wregs);
              w_addr_nx = r_addr + 6'd1;
            end
            ST_ADDR_WR: begin
              w_addr_nx  = w_rx_byte[5:0];
              w_state_nx = ST_DATA_WR;
            end
            ST_DATA_WR: begin
              if (is_writable(r_addr)) begin
                if ((r_addr == ADDR_SOFT_RESET) && (w_rx_byte == SOFT_RESET_KEY)) begin
                  w_wregs_nx = wregs_default();
                end else begin
                  w_wregs_nx[wreg_index(r_addr[3:0])] = w_rx_byte;
                end
                w_wr_strobe_nx = 1'b1;
                w_wr_addr_nx   = r_addr;
                w_wr_data_nx   = w_rx_byte;
              end else begin
                w_wr_strobe_nx = 1'b0;
              end
              w_addr_nx = r_addr + 6'd1;
            end
            ST_IGNORE: begin
              w_state_nx = ST_IGNORE;
            end
            default: begin
              w_state_nx = ST_IDLE;
            end
          endcase
        end else begin
          w_state_nx = r_state;
        end
      end else begin
        w_rx_nx = r_rx;
      end

      if (w_sclk_fall) begin
        if (r_state == ST_IGNORE) begin
          w_miso_nx = 1'b0;
          w_tx_nx   = 8'h00;
        end else begin
          w_miso_nx = r_tx[7];
          w_tx_nx   = {r_tx[6:0], 1'b0};
        end
      end else begin
        w_miso_nx = r_miso;
      end
    end

    // A new sample beats a simultaneous clear
    if (sample_valid) begin
      w_dready_nx = 1'b1;
    end else if (w_dready_clr) begin
      w_dready_nx = 1'b0;
    end else begin
      w_dready_nx = r_dready;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt   <= 3'd0;
      r_rx        <= 8'h00;
      r_tx        <= 8'h00;
      r_addr      <= 6'd0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 6'd0;
      r_wr_data   <= 8'h00;
      r_wregs     <= wregs_default();
      r_snap_x    <= 12'h000;
      r_snap_y    <= 12'h000;
      r_snap_z    <= 12'h000;
      r_dready    <= 1'b0;
    end else begin
      r_bit_cnt   <= w_bit_cnt_nx;
      r_rx        <= w_rx_nx;
      r_tx        <= w_tx_nx;
      r_addr      <= w_addr_nx;
      r_miso      <= w_miso_nx;
      r_miso_oe   <= ~w_cs_sync;
      r_wr_strobe <= w_wr_strobe_nx;
      r_wr_addr   <= w_wr_addr_nx;
      r_wr_data   <= w_wr_data_nx;
      r_wregs     <= w_wregs_nx;
      r_snap_x    <= w_snap_x_nx;
      r_snap_y    <= w_snap_y_nx;
      r_snap_z    <= w_snap_z_nx;
      r_dready    <= w_dready_nx;
    end
  end

endmodule
